// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Sequential controller for the multicycle RISC-V datapath. A Moore main FSM
// sequences each instruction through Fetch/Decode/Execute/Writeback steps. A
// combinational ALU decoder and an immediate-format decoder complete the unit.
// Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset (state -> Fetch)
//   op         : instruction[6:0]
//   funct3     : instruction[14:12]
//   funct7b5   : instruction[30]
//   zero       : ALU result == 0 in the current cycle
//   PCWrite    : PC register enable
//   AdrSrc     : memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   : data memory write enable
//   IRWrite    : instruction register / OldPC enable
//   ResultSrc  : result mux (00 ALUOut, 01 Data, 10 ALU result)
//   ALUSrcA    : srcA mux (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    : srcB mux (00 rs2, 01 ImmExt, 10 constant 4)
//   RegWrite   : register file write enable
//   ImmSrc     : immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUControl : ALU operation (000 add, 001 sub, 010 and, 011 or,
//                100 xor, 101 slt)
//   state      : current FSM state encoding (0..10), for debug
// -----------------------------------------------------------------------------
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  // Opcodes of the supported instruction classes.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // ALU operation codes.
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    S0Fetch    = 4'd0,
    S1Decode   = 4'd1,
    S2MemAdr   = 4'd2,
    S3MemRead  = 4'd3,
    S4MemWB    = 4'd4,
    S5MemWrite = 4'd5,
    S6ExecuteR = 4'd6,
    S7AluWB    = 4'd7,
    S8ExecuteI = 4'd8,
    S9Jal      = 4'd9,
    S10Beq     = 4'd10
  } stateT;

  stateT stateReg;
  stateT nextState;
  stateT decodeState;

  // Internal control signals produced by the state decode.
  logic       pcUpdate;
  logic       branch;
  logic [1:0] aluOp;
  logic       irWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs before any of them update at the clock edge.
  always_ff @(posedge clk) begin
    if (reset) stateReg <= S0Fetch;
    else       stateReg <= nextState;
  end

  assign state = stateReg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = S0Fetch;
    unique case (stateReg)
      S0Fetch:    nextState = S1Decode;
      S1Decode: begin
        unique case (op)
          OpLoad, OpStore: nextState = S2MemAdr;
          OpRType:         nextState = S6ExecuteR;
          OpIType:         nextState = S8ExecuteI;
          OpJal:           nextState = S9Jal;
          OpBranch:        nextState = S10Beq;
          default:         nextState = S0Fetch;   // illegal: back to fetch
        endcase
      end
      S2MemAdr:   nextState = (op == OpLoad) ? S3MemRead : S5MemWrite;
      S3MemRead:  nextState = S4MemWB;
      S4MemWB:    nextState = S0Fetch;
      S5MemWrite: nextState = S0Fetch;
      S6ExecuteR: nextState = S7AluWB;
      S7AluWB:    nextState = S0Fetch;
      S8ExecuteI: nextState = S7AluWB;
      S9Jal:      nextState = S7AluWB;
      S10Beq:     nextState = S0Fetch;
      default:    nextState = S0Fetch;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  // While reset is high the outputs show the Fetch decode regardless of the
  // register contents, so a reset asserted mid-instruction never leaks the
  // old state's selects; the write enables are additionally masked below.
  assign decodeState = reset ? S0Fetch : stateReg;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    aluOp       = 2'b00;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    unique case (decodeState)
      S0Fetch: begin
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
      end
      S1Decode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S2MemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S3MemRead: begin
        AdrSrc = 1'b1;
      end
      S4MemWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      S5MemWrite: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      S6ExecuteR: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      S7AluWB: begin
        regWriteRaw = 1'b1;
      end
      S8ExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      S9Jal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      S10Beq: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch taken only when the ALU subtraction in BEQ produces zero.
  assign PCWrite  = ~reset & (pcUpdate | (branch & zero));
  assign IRWrite  = ~reset & irWriteRaw;
  assign MemWrite = ~reset & memWriteRaw;
  assign RegWrite = ~reset & regWriteRaw;

  // ---------------------------------------------------------------------------
  // Immediate format decode (depends on op only, valid in every state)
  // ---------------------------------------------------------------------------
  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------------
  // funct3 000 is sub only for R-type with funct7[5] set; op[5] separates
  // R-type (0110011) from I-type (0010011), where bit 30 is immediate data.
  logic rTypeSub;
  assign rTypeSub = op[5] & funct7b5;

  always_comb begin
    ALUControl = AluAdd;
    unique case (aluOp)
      2'b00: ALUControl = AluAdd;
      2'b01: ALUControl = AluSub;
      2'b10: begin
        unique case (funct3)
          3'b000:  ALUControl = rTypeSub ? AluSub : AluAdd;
          3'b010:  ALUControl = AluSlt;
          3'b100:  ALUControl = AluXor;
          3'b110:  ALUControl = AluOr;
          3'b111:  ALUControl = AluAnd;
          default: ALUControl = AluAdd;
        endcase
      end
      default: ALUControl = AluAdd;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Self-checking bench for multicycle_control_unit. A reference model builds,
// per instruction, the list of cycles it must take and the control word
// expected in each cycle; every cycle is compared at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int vectors = 0;
  int errors  = 0;

  multicycle_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;

  // One cycle's full control word.
  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       rw;
    logic [1:0] imm;
    logic [2:0] alu;
  } ctrlT;

  function automatic ctrlT observed();
    ctrlT c;
    c.st  = state;     c.pcw = PCWrite;   c.adr = AdrSrc;
    c.mw  = MemWrite;  c.irw = IRWrite;   c.res = ResultSrc;
    c.sa  = ALUSrcA;   c.sb  = ALUSrcB;   c.rw  = RegWrite;
    c.imm = ImmSrc;    c.alu = ALUControl;
    return c;
  endfunction

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Operation an R/I-type instruction performs, as an ALUControl code.
  function automatic logic [2:0] arithFor(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
    case (f3)
      3'b000:  return (o == RTY && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit isLegal(input logic [6:0] o);
    return o == LW || o == SW || o == RTY || o == ITY || o == JAL || o == BEQ;
  endfunction

  // A cycle with everything idle, in a given state, for a given instruction.
  function automatic ctrlT idle(input int st, input logic [6:0] o);
    ctrlT c;
    c = '0;
    c.st  = 4'(st);
    c.imm = immFor(o);
    return c;
  endfunction

  function automatic ctrlT fetchWord(input logic [6:0] o);
    ctrlT c;
    c = idle(0, o);
    c.irw = 1'b1; c.pcw = 1'b1; c.sb = 2'b10; c.res = 2'b10;
    return c;
  endfunction

  // Run one instruction from its Fetch cycle back to the next Fetch cycle,
  // comparing every cycle against the model's expected control words.
  task automatic execInstr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic zBeq);
    ctrlT exp[$];
    ctrlT c;
    ctrlT got;
    logic zq[$];
    exp.push_back(fetchWord(o));
    c = idle(1, o); c.sa = 2'b01; c.sb = 2'b01; exp.push_back(c);
    if (o == LW || o == SW) begin
      c = idle(2, o); c.sa = 2'b10; c.sb = 2'b01; exp.push_back(c);
      if (o == LW) begin
        c = idle(3, o); c.adr = 1'b1; exp.push_back(c);
        c = idle(4, o); c.res = 2'b01; c.rw = 1'b1; exp.push_back(c);
      end else begin
        c = idle(5, o); c.adr = 1'b1; c.mw = 1'b1; exp.push_back(c);
      end
    end else if (o == RTY || o == ITY) begin
      c = idle(o == RTY ? 6 : 8, o);
      c.sa = 2'b10; c.sb = (o == RTY) ? 2'b00 : 2'b01; c.alu = arithFor(o, f3, f7);
      exp.push_back(c);
      c = idle(7, o); c.rw = 1'b1; exp.push_back(c);
    end else if (o == JAL) begin
      c = idle(9, o); c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; exp.push_back(c);
      c = idle(7, o); c.rw = 1'b1; exp.push_back(c);
    end else if (o == BEQ) begin
      c = idle(10, o); c.sa = 2'b10; c.alu = 3'b001; c.pcw = zBeq; exp.push_back(c);
    end
    // zero is random except in BEQ, where the model uses zBeq.
    foreach (exp[i]) zq.push_back(exp[i].st == 4'd10 ? zBeq : 1'($urandom));

    op = o; funct3 = f3; funct7b5 = f7;
    foreach (exp[i]) begin
      zero = zq[i];
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got st=%0d ctrl=%h, expected st=%0d ctrl=%h",
                 name, i, got.st, got, exp[i].st, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctrlT expR;
    ctrlT got;
    reset = 1'b1; op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    expR = idle(0, op); expR.sb = 2'b10; expR.res = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      got = observed();
      vectors++;
      if (got !== expR) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h, expected %h", k, got, expR);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUControl !== 3'b000 || state !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: got irw=%b pcw=%b alu=%b st=%0d, expected 1 1 000 0",
               IRWrite, PCWrite, ALUControl, state);
    end
    // Illegal opcode: decode then straight back to fetch.
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd1 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_decode: got st=%0d rw=%b mw=%b, expected 1 0 0",
               state, RegWrite, MemWrite);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    execInstr("lw", LW, 3'b010, 1'b0, 1'b0);
    execInstr("lw_f7", LW, 3'b010, 1'b1, 1'b1);
  endtask

  task automatic test_alu();
    execInstr("r_sub", RTY, 3'b000, 1'b1, 1'b0);
    execInstr("addi_f7", ITY, 3'b000, 1'b1, 1'b0);
    execInstr("r_add", RTY, 3'b000, 1'b0, 1'b0);
    execInstr("r_slt", RTY, 3'b010, 1'b0, 1'b0);
    execInstr("i_xor", ITY, 3'b100, 1'b0, 1'b0);
    execInstr("r_or", RTY, 3'b110, 1'b1, 1'b0);
    execInstr("i_and", ITY, 3'b111, 1'b0, 1'b0);
    execInstr("r_f3_001", RTY, 3'b001, 1'b1, 1'b0);
  endtask

  task automatic test_beq();
    execInstr("beq_taken", BEQ, 3'b000, 1'b0, 1'b1);
    execInstr("beq_not_taken", BEQ, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_sw_jal_illegal();
    execInstr("sw", SW, 3'b010, 1'b0, 1'b0);
    execInstr("jal", JAL, 3'b000, 1'b0, 1'b0);
    execInstr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    // Fetch, Decode, MemAdr, then assert reset while in MemRead.
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd3 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCWrite !== 1'b0 ||
        IRWrite !== 1'b0 || AdrSrc !== 1'b0 || ALUSrcB !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_s3: got st=%0d rw=%b mw=%b pcw=%b irw=%b adr=%b sb=%b, expected 3 0 0 0 0 0 10",
               state, RegWrite, MemWrite, PCWrite, IRWrite, AdrSrc, ALUSrcB);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: got st=%0d rw=%b, expected 0 0", state, RegWrite);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    execInstr("lw_after_reset", LW, 3'b010, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] o;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(6))
        0: o = LW;
        1: o = SW;
        2: o = RTY;
        3: o = ITY;
        4: o = JAL;
        5: o = BEQ;
        default: begin
          o = 7'($urandom);
          while (isLegal(o)) o = 7'($urandom);
        end
      endcase
      execInstr("random", o, 3'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_beq();
    test_sw_jal_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
